dot_product_engine: RTL and testbench

- Parametrised, multi-lane successor to the NPU's single-MAC dot-product block.
- Computes sum(a[i]*b[i]) over a VEC_LEN-element operand pair, processing LANES elements per cycle.
- Signed/unsigned operand mode, wide accumulator, and saturating or wrapping output narrowing.
- Sits between the operand buffers and the NPU result writeback; start/busy/done handshake toward the sequencer.

---
 rtl/npu_pkg.sv | 43 ++++
 rtl/dot_lane_mult.sv | 29 ++
 rtl/dot_product_engine.sv | 144 ++++++++++++++
 tb/tb_dot_product_engine.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: dot-product FSM states, width helpers and the
// result narrowing function used by the NPU datapath blocks.
package npu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } dot_state_e;

   localparam int NARROW_W = 64;

   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // value must arrive sign-extended (signed mode) or zero-extended to NARROW_W
   function automatic logic [NARROW_W-1:0] sat_narrow(
      input  logic signed [NARROW_W-1:0] value,
      input  int                         out_w,
      input  logic                       is_signed,
      input  logic                       saturate,
      output logic                       ovf
   );
      logic signed [NARROW_W-1:0] hi;
      logic signed [NARROW_W-1:0] lo;
      if (is_signed) begin
         hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
         lo = -(64'sd1 <<< (out_w - 1));
      end else begin
         hi = (64'sd1 <<< out_w) - 64'sd1;
         lo = '0;
      end
      ovf = (value > hi) || (value < lo);
      if (saturate && (value > hi))
         return hi;
      if (saturate && (value < lo))
         return lo;
      return value;
   endfunction

endpackage

// File: rtl/dot_lane_mult.sv
// One registered DATA_W x DATA_W lane multiplier with clock enable; operands
// are sign- or zero-extended according to signed_mode.
module dot_lane_mult #(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  ce,
   input  logic                  signed_mode,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic [2*DATA_W-1:0]   product
);

   logic signed [DATA_W:0]     a_ext;
   logic signed [DATA_W:0]     b_ext;
   logic signed [2*DATA_W-1:0] full;

   assign a_ext = signed'({signed_mode & a[DATA_W-1], a});
   assign b_ext = signed'({signed_mode & b[DATA_W-1], b});

   // The low 2*DATA_W bits of the extended product are exact in both modes
   assign full = (2*DATA_W)'(a_ext) * (2*DATA_W)'(b_ext);

   always_ff @(posedge clk) begin
      if (ce)
         product <= full;
   end

endmodule

// File: rtl/dot_product_engine.sv
// Multi-lane dot-product engine: LANES registered multipliers feed a wide
// accumulator; the sum is narrowed (saturate or wrap) when the run completes.
module dot_product_engine
   import npu_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int VEC_LEN = 32,
   parameter int LANES   = 2,
   parameter int ACC_W   = 24,
   parameter int OUT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      signed_mode,
   input  logic                      saturate,
   input  logic [VEC_LEN*DATA_W-1:0] a_flat,
   input  logic [VEC_LEN*DATA_W-1:0] b_flat,
   output logic                      busy,
   output logic                      done,
   output logic [OUT_W-1:0]          result,
   output logic                      overflow
);

   localparam int IDX_W    = idx_width(VEC_LEN);
   localparam int PROD_W   = 2 * DATA_W;
   localparam int VEC_W    = VEC_LEN * DATA_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - LANES);
   localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES);

   dot_state_e          state;
   dot_state_e          state_next;
   logic                accept;
   logic                mac_en;
   logic [VEC_W-1:0]    a_sh;
   logic [VEC_W-1:0]    b_sh;
   logic                mode_signed;
   logic                mode_sat;
   logic [IDX_W-1:0]    index;
   logic [PROD_W-1:0]   prod [LANES];
   logic                prod_valid;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    lane_sum;
   logic [ACC_W-1:0]    acc_next;
   logic [OUT_W-1:0]    result_next;
   logic                ovf_next;

   assign mac_en = (state == MAC);
   assign busy   = (state == MAC) || (state == DRAIN);
   assign done   = (state == DONE);

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = MAC;
            end
         end
         MAC: begin
            if (index == LAST_IDX)
               state_next = DRAIN;
         end
         DRAIN: state_next = DONE;
         DONE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = MAC;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [DATA_W-1:0] a_el;
      logic [DATA_W-1:0] b_el;

      assign a_el = a_sh[(int'(index) + l) * DATA_W +: DATA_W];
      assign b_el = b_sh[(int'(index) + l) * DATA_W +: DATA_W];

      dot_lane_mult #(.DATA_W(DATA_W)) u_mult (
         .clk         (clk),
         .ce          (mac_en),
         .signed_mode (mode_signed),
         .a           (a_el),
         .b           (b_el),
         .product     (prod[l])
      );
   end

   // Result is registered on the DRAIN edge, so it must see the final sum now
   always_comb begin
      lane_sum = '0;
      for (int l = 0; l < LANES; l++)
         lane_sum = lane_sum + {{(ACC_W-PROD_W){mode_signed & prod[l][PROD_W-1]}}, prod[l]};
      acc_next    = prod_valid ? (acc + lane_sum) : acc;
      ovf_next    = 1'b0;
      result_next = OUT_W'(sat_narrow(
                       {{(NARROW_W-ACC_W){mode_signed & acc_next[ACC_W-1]}}, acc_next},
                       OUT_W, mode_signed, mode_sat, ovf_next));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         index      <= '0;
         acc        <= '0;
         prod_valid <= 1'b0;
         result     <= '0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_next;
         prod_valid <= mac_en;
         if (accept) begin
            index <= '0;
            acc   <= '0;
         end else begin
            if (mac_en)
               index <= index + IDX_STEP;
            acc <= acc_next;
         end
         if (state == DRAIN) begin
            result   <= result_next;
            overflow <= ovf_next;
         end
      end
   end

   // Shadow copies let the operand buffers move on right after acceptance
   always_ff @(posedge clk) begin
      if (accept) begin
         a_sh        <= a_flat;
         b_sh        <= b_flat;
         mode_signed <= signed_mode;
         mode_sat    <= saturate;
      end
   end

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench for dot_product_engine: default-parameter instance plus a
// LANES=4, VEC_LEN=16 instance, checked against hand-computed results.
module tb_dot_product_engine;

   localparam int DW = 8;
   localparam int VL = 32;
   localparam int OW = 16;
   localparam int VL4 = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic              start;
   logic              signed_mode;
   logic              saturate;
   logic [VL*DW-1:0]  a_flat;
   logic [VL*DW-1:0]  b_flat;
   logic              busy;
   logic              done;
   logic [OW-1:0]     result;
   logic              overflow;

   logic              start4;
   logic [VL4*DW-1:0] a4;
   logic [VL4*DW-1:0] b4;
   logic              busy4;
   logic              done4;
   logic [OW-1:0]     result4;
   logic              overflow4;

   int total = 0;
   int bad   = 0;

   dot_product_engine #(
      .DATA_W(DW), .VEC_LEN(VL), .LANES(2), .ACC_W(24), .OUT_W(OW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .signed_mode (signed_mode),
      .saturate    (saturate),
      .a_flat      (a_flat),
      .b_flat      (b_flat),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .overflow    (overflow)
   );

   dot_product_engine #(
      .DATA_W(DW), .VEC_LEN(VL4), .LANES(4), .ACC_W(24), .OUT_W(OW)
   ) dut4 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start4),
      .signed_mode (1'b0),
      .saturate    (1'b1),
      .a_flat      (a4),
      .b_flat      (b4),
      .busy        (busy4),
      .done        (done4),
      .result      (result4),
      .overflow    (overflow4)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
         $error("[TB] check %s did not match", tag);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic sm, input logic sat);
      a_flat      = {VL{av}};
      b_flat      = {VL{bv}};
      signed_mode = sm;
      saturate    = sat;
      start       = 1'b1;
   endtask

   // Cycle 0 is the cycle start is presented in; returns -1 if done never shows
   task automatic waitDone(input int limit, input int disturb_at, output int done_at, output int busy_cnt);
      done_at  = -1;
      busy_cnt = 0;
      for (int i = 1; i <= limit; i++) begin
         tick();
         if (i == 1)
            start = 1'b0;
         if (disturb_at > 0 && i == disturb_at) begin
            start       = 1'b1;
            a_flat      = {VL{8'h07}};
            b_flat      = {VL{8'h09}};
            signed_mode = 1'b1;
            saturate    = 1'b0;
         end
         if (disturb_at > 0 && i == disturb_at + 2)
            start = 1'b0;
         if (busy)
            busy_cnt++;
         if (done) begin
            done_at = i;
            break;
         end
      end
   endtask

   initial begin
      int d;
      int bc;
      int pulses;

      rst_n       = 1'b0;
      start       = 1'b0;
      signed_mode = 1'b0;
      saturate    = 1'b0;
      a_flat      = '0;
      b_flat      = '0;
      start4      = 1'b0;
      a4          = '0;
      b4          = '0;
      tick();
      tick();
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_result", 32'(result), 32'd0);
      checkOutput("reset_overflow", 32'(overflow), 32'd0);
      checkOutput("reset_busy4", 32'(busy4), 32'd0);
      rst_n = 1'b1;
      tick();

      applyStimulus(8'h01, 8'h01, 1'b0, 1'b1);
      waitDone(40, 0, d, bc);
      checkOutput("ones_latency", 32'(d), 32'd18);
      checkOutput("ones_busy_cycles", 32'(bc), 32'd17);
      checkOutput("ones_result", 32'(result), 32'd32);
      checkOutput("ones_overflow", 32'(overflow), 32'd0);
      tick();
      checkOutput("done_pulse_width", 32'(done), 32'd0);
      checkOutput("result_hold", 32'(result), 32'd32);

      applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b1);
      waitDone(40, 0, d, bc);
      checkOutput("max_sat_result", 32'(result), 32'hFFFF);
      checkOutput("max_sat_overflow", 32'(overflow), 32'd1);
      applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0);
      waitDone(40, 0, d, bc);
      checkOutput("max_wrap_result", 32'(result), 32'hC020);
      checkOutput("max_wrap_overflow", 32'(overflow), 32'd1);

      applyStimulus(8'hFF, 8'h01, 1'b1, 1'b1);
      waitDone(40, 0, d, bc);
      checkOutput("signed_neg_result", 32'(result), 32'hFFE0);
      checkOutput("signed_neg_overflow", 32'(overflow), 32'd0);
      applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1);
      waitDone(40, 0, d, bc);
      checkOutput("unsigned_ff_result", 32'(result), 32'h1FE0);
      checkOutput("unsigned_ff_overflow", 32'(overflow), 32'd0);

      // -128 * 127 * 32 = -520192, below the signed 16-bit floor
      applyStimulus(8'h80, 8'h7F, 1'b1, 1'b1);
      waitDone(40, 0, d, bc);
      checkOutput("signed_floor_sat", 32'(result), 32'h8000);
      checkOutput("signed_floor_overflow", 32'(overflow), 32'd1);
      applyStimulus(8'h80, 8'h7F, 1'b1, 1'b0);
      waitDone(40, 0, d, bc);
      checkOutput("signed_floor_wrap", 32'(result), 32'h1000);

      tick();
      applyStimulus(8'h02, 8'h03, 1'b0, 1'b1);
      waitDone(40, 5, d, bc);
      checkOutput("midrun_start_latency", 32'(d), 32'd18);
      checkOutput("midrun_start_result", 32'(result), 32'd192);
      checkOutput("midrun_start_overflow", 32'(overflow), 32'd0);
      applyStimulus(8'h01, 8'h05, 1'b0, 1'b1);
      waitDone(40, 0, d, bc);
      checkOutput("b2b_latency", 32'(d), 32'd18);
      checkOutput("b2b_result", 32'(result), 32'd160);

      applyStimulus(8'h01, 8'h01, 1'b0, 1'b1);
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++)
         tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_result", 32'(result), 32'd0);
      checkOutput("abort_overflow", 32'(overflow), 32'd0);
      pulses = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (done)
            pulses++;
      end
      checkOutput("abort_no_done", 32'(pulses), 32'd0);
      applyStimulus(8'h03, 8'h04, 1'b0, 1'b1);
      waitDone(40, 0, d, bc);
      checkOutput("after_abort_latency", 32'(d), 32'd18);
      checkOutput("after_abort_result", 32'(result), 32'd384);

      for (int i = 0; i < VL4; i++) begin
         a4[i*DW +: DW] = 8'(i);
         b4[i*DW +: DW] = 8'(i);
      end
      start4 = 1'b1;
      d = -1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (i == 1)
            start4 = 1'b0;
         if (done4) begin
            d = i;
            break;
         end
      end
      checkOutput("lanes4_latency", 32'(d), 32'd6);
      checkOutput("lanes4_result", 32'(result4), 32'd1240);
      checkOutput("lanes4_overflow", 32'(overflow4), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
